// File: rtl/ram_loader.sv
// Programs the 16-byte SAP RAM through its programming-mode port from a byte stream,
// then optionally reads every written location back and flags the first mismatch.
module ram_loader #(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 2,
    parameter int HOLD_CYCLES  = 1,
    parameter int VERIFY       = 1
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  prog_mode,
    output logic [ADDR_WIDTH-1:0] prog_addr,
    output logic                  prog_addr_load,
    output logic [DATA_WIDTH-1:0] prog_data,
    output logic                  prog_we,
    output logic                  ram_oe,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] err_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BYTE,
        S_W_SETUP,
        S_W_PULSE,
        S_W_HOLD,
        S_V_SETUP,
        S_V_CHECK,
        S_DONE
    } state_t;

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] last_q, last_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] prog_data_q, prog_data_d;
    logic                  error_q, error_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

    // Copy of what was written, used as the reference during read-back.
    logic [DATA_WIDTH-1:0] shadow_q [DEPTH];
    logic                  shadow_we;
    logic                  mismatch;

    assign mismatch = (ram_rdata != shadow_q[addr_q]);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        prog_data_d = prog_data_q;
        error_d     = error_q;
        err_addr_d  = err_addr_q;
        shadow_we   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    last_d     = last_addr;
                    addr_d     = '0;
                    cnt_d      = '0;
                    error_d    = 1'b0;
                    err_addr_d = '0;
                    state_d    = S_WAIT_BYTE;
                end
            end
            S_WAIT_BYTE: begin
                if (in_valid) begin
                    prog_data_d = in_data;
                    shadow_we   = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_W_SETUP;
                end
            end
            S_W_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_W_PULSE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_W_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_W_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_W_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    // The pass ends exactly at last_addr, so the counter never wraps.
                    if (addr_q == last_q) begin
                        if (VERIFY != 0) begin
                            addr_d  = '0;
                            state_d = S_V_SETUP;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        state_d = S_WAIT_BYTE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_V_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_V_CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_V_CHECK: begin
                if (mismatch && !error_q) begin
                    error_d    = 1'b1;
                    err_addr_d = addr_q;
                end
                if (addr_q == last_q) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    state_d = S_V_SETUP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            last_q      <= '0;
            cnt_q       <= '0;
            prog_data_q <= '0;
            error_q     <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            prog_data_q <= prog_data_d;
            error_q     <= error_d;
            err_addr_q  <= err_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (shadow_we) begin
            shadow_q[addr_q] <= in_data;
        end
    end

    // All strobes decode from the registered state, so clear drops them on its own edge.
    assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
    assign prog_mode      = busy;
    assign done           = (state_q == S_DONE);
    assign in_ready       = (state_q == S_WAIT_BYTE);
    assign prog_we        = (state_q == S_W_PULSE);
    assign ram_oe         = (state_q == S_V_SETUP) || (state_q == S_V_CHECK);
    assign prog_addr_load = ((state_q == S_W_SETUP) || (state_q == S_V_SETUP)) && (cnt_q == '0);
    assign prog_addr      = addr_q;
    assign prog_data      = prog_data_q;
    assign error          = error_q;
    assign err_addr       = err_addr_q;

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: RAM model with fault injection, table-driven load scenarios,
// hand-written clear/restart/no-verify sequences and randomized loads against a reference model.
module tb_ram_loader;

    logic       clk;
    logic       clear;
    logic       start;
    logic [3:0] last_addr;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       prog_mode;
    logic [3:0] prog_addr;
    logic       prog_addr_load;
    logic [7:0] prog_data;
    logic       prog_we;
    logic       ram_oe;
    logic [7:0] ram_rdata;
    logic       busy;
    logic       done;
    logic       error;
    logic [3:0] err_addr;

    logic       nv_start;
    logic [3:0] nv_last;
    logic [7:0] nv_in_data;
    logic       nv_in_valid;
    logic       nv_in_ready;
    logic       nv_prog_mode;
    logic [3:0] nv_prog_addr;
    logic       nv_prog_addr_load;
    logic [7:0] nv_prog_data;
    logic       nv_prog_we;
    logic       nv_ram_oe;
    logic [7:0] nv_ram_rdata;
    logic       nv_busy;
    logic       nv_done;
    logic       nv_error;
    logic [3:0] nv_err_addr;

    int checks = 0;
    int errors = 0;

    ram_loader #(.VERIFY(1)) u_dut (
        .clk(clk), .clear(clear), .start(start), .last_addr(last_addr),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .prog_mode(prog_mode), .prog_addr(prog_addr), .prog_addr_load(prog_addr_load),
        .prog_data(prog_data), .prog_we(prog_we), .ram_oe(ram_oe), .ram_rdata(ram_rdata),
        .busy(busy), .done(done), .error(error), .err_addr(err_addr)
    );

    ram_loader #(.VERIFY(0)) u_dut_nv (
        .clk(clk), .clear(clear), .start(nv_start), .last_addr(nv_last),
        .in_data(nv_in_data), .in_valid(nv_in_valid), .in_ready(nv_in_ready),
        .prog_mode(nv_prog_mode), .prog_addr(nv_prog_addr), .prog_addr_load(nv_prog_addr_load),
        .prog_data(nv_prog_data), .prog_we(nv_prog_we), .ram_oe(nv_ram_oe), .ram_rdata(nv_ram_rdata),
        .busy(nv_busy), .done(nv_done), .error(nv_error), .err_addr(nv_err_addr)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- RAM model ----------------
    logic [7:0] mem [16];
    logic [3:0] mar = 4'd0;
    bit         corrupt_en [16];
    logic [7:0] corrupt_val [16];
    logic [7:0] src [16];

    always @(posedge clk) begin
        if (prog_we) mem[mar] <= prog_data;
        if (prog_addr_load) mar <= prog_addr;
    end

    always_comb begin
        ram_rdata = corrupt_en[mar] ? corrupt_val[mar] : mem[mar];
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    logic [11:0] got_q [$];
    logic [11:0] exp_q [$];
    logic [11:0] cur_wr;
    int          we_len = 0;
    bit          mon_en = 1'b1;
    int          oe_cycles = 0;
    int          busy_cycles = 0;
    int          nv_we_cycles = 0;
    int          nv_oe_cycles = 0;
    logic [3:0]  nv_we_addr;
    logic [7:0]  nv_we_data;

    always @(negedge clk) begin
        check("inv_we_oe", 32'(prog_we & ram_oe), 0);
        check("inv_ready", 32'(in_ready & (!busy | prog_we | ram_oe | prog_addr_load)), 0);
        check("inv_mode", 32'(prog_mode), 32'(busy));
        check("inv_done", 32'(done & busy), 0);
        if (!mon_en) begin
            we_len = 0;
        end else if (prog_we) begin
            we_len++;
            cur_wr = {mar, prog_data};
        end else if (we_len != 0) begin
            got_q.push_back(cur_wr);
            check("pulse_len", we_len, 2);
            we_len = 0;
        end
        if (ram_oe) oe_cycles++;
        if (busy) busy_cycles++;
        if (nv_prog_we) begin
            nv_we_cycles++;
            nv_we_addr = nv_prog_addr;
            nv_we_data = nv_prog_data;
        end
        if (nv_ram_oe) nv_oe_cycles++;
    end

    // ---------------- reference model ----------------
    function automatic void model_verify(input logic [3:0] last, output bit e, output logic [3:0] ea);
        e  = 1'b0;
        ea = 4'd0;
        for (int i = 0; i <= int'(last); i++) begin
            if (!e && corrupt_en[i] && corrupt_val[i] != src[i]) begin
                e  = 1'b1;
                ea = 4'(i);
            end
        end
    endfunction

    // ---------------- drivers ----------------
    task automatic stream_bytes(input int n, input int gap, input bit stray, input logic [3:0] last);
        int idx = 0;
        int cyc = 0;
        bit tog = 1'b0;
        bit sent = 1'b0;
        bit drv;
        while (idx < n && cyc < 1000) begin
            case (gap)
                0: drv = 1'b1;
                1: begin drv = tog; tog = ~tog; end
                default: drv = ($urandom_range(0, 1) == 1);
            endcase
            in_valid = drv;
            in_data  = drv ? src[idx] : 8'($urandom);
            start    = 1'b0;
            #1;
            if (stray && !sent && idx == 1 && in_ready) begin
                start     = 1'b1;
                last_addr = ~last;
                sent      = 1'b1;
            end
            if (drv && in_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check("stream_accepted", idx, n);
    endtask

    task automatic wait_done();
        int cyc = 0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("done_timeout", 32'(done), 1);
    endtask

    task automatic run_case(input logic [3:0] last, input int gap, input bit stray,
                            input bit exp_err, input logic [3:0] exp_ea, input string tag);
        int n;
        n = int'(last) + 1;
        @(negedge clk);
        got_q.delete();
        exp_q.delete();
        oe_cycles   = 0;
        busy_cycles = 0;
        start       = 1'b1;
        last_addr   = last;
        @(negedge clk);
        start     = 1'b0;
        last_addr = 4'($urandom);
        check({tag, "_start_busy"}, 32'(busy), 1);
        check({tag, "_start_done"}, 32'(done), 0);
        check({tag, "_start_err"}, {31'd0, error}, 0);
        check({tag, "_start_ea"}, 32'(err_addr), 0);
        check({tag, "_start_ready"}, 32'(in_ready), 1);
        stream_bytes(n, gap, stray, last);
        wait_done();
        for (int i = 0; i < n; i++) exp_q.push_back({4'(i), src[i]});
        check({tag, "_nwrites"}, got_q.size(), exp_q.size());
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            check({tag, "_write"}, 32'(got_q[i]), 32'(exp_q[i]));
        end
        check({tag, "_error"}, 32'(error), 32'(exp_err));
        check({tag, "_err_addr"}, 32'(err_addr), 32'(exp_ea));
        check({tag, "_oe_cycles"}, oe_cycles, 2 * n);
        check({tag, "_busy_end"}, 32'(busy), 0);
        check({tag, "_mode_end"}, 32'(prog_mode), 0);
        if (gap == 0) check({tag, "_busy_cycles"}, busy_cycles, 7 * n);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  last;
        int          gap;
        logic [7:0]  base;
        logic [7:0]  step;
        logic [15:0] cmask;
        bit          exp_err;
        logic [3:0]  exp_ea;
    } vec_t;

    vec_t vecs [3];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit         m_err;
        logic [3:0] m_ea;
        logic [3:0] r_last;
        int         r_gap;
        bit         hit;
        int         idx;

        vecs[0] = '{last: 4'd3,  gap: 0, base: 8'h11, step: 8'h11, cmask: 16'h0000, exp_err: 1'b0, exp_ea: 4'd0};
        vecs[1] = '{last: 4'd15, gap: 1, base: 8'h00, step: 8'h01, cmask: 16'h0000, exp_err: 1'b0, exp_ea: 4'd0};
        vecs[2] = '{last: 4'd15, gap: 2, base: 8'h00, step: 8'h01, cmask: 16'h0220, exp_err: 1'b1, exp_ea: 4'd5};

        for (int i = 0; i < 16; i++) begin
            corrupt_en[i]  = 1'b0;
            corrupt_val[i] = 8'hFF;
            mem[i]         = 8'h00;
            src[i]         = 8'h00;
        end
        clear = 1'b1; start = 1'b0; last_addr = 4'd0; in_data = 8'd0; in_valid = 1'b0;
        nv_start = 1'b0; nv_last = 4'd0; nv_in_data = 8'd0; nv_in_valid = 1'b0; nv_ram_rdata = 8'd0;
        repeat (3) @(negedge clk);
        clear = 1'b0;

        // reset state
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_prog_mode", 32'(prog_mode), 0);
        check("rst_addr_load", 32'(prog_addr_load), 0);
        check("rst_prog_we", 32'(prog_we), 0);
        check("rst_ram_oe", 32'(ram_oe), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        check("rst_prog_addr", 32'(prog_addr), 0);
        check("rst_prog_data", 32'(prog_data), 0);
        check("rst_err_addr", 32'(err_addr), 0);

        // table-driven scenarios
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < 16; i++) begin
                src[i]        = vecs[v].base + 8'(i) * vecs[v].step;
                corrupt_en[i] = vecs[v].cmask[i];
                corrupt_val[i] = 8'hFF;
            end
            run_case(vecs[v].last, vecs[v].gap, 1'b0, vecs[v].exp_err, vecs[v].exp_ea, $sformatf("vec%0d", v));
        end
        for (int i = 0; i < 16; i++) corrupt_en[i] = 1'b0;

        // clear during the write strobe of the byte at address 2
        for (int i = 0; i < 16; i++) src[i] = 8'($urandom);
        @(negedge clk);
        start = 1'b1; last_addr = 4'd5;
        @(negedge clk);
        start = 1'b0;
        mon_en = 1'b0;
        hit = 1'b0;
        idx = 0;
        for (int c = 0; c < 200; c++) begin
            if (prog_we && prog_addr == 4'd2) begin
                hit = 1'b1;
                break;
            end
            in_valid = 1'b1;
            in_data  = src[idx];
            #1;
            if (in_ready && idx < 15) idx++;
            @(negedge clk);
        end
        check("t4_reached_pulse", 32'(hit), 1);
        clear = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        check("t4_prog_we", 32'(prog_we), 0);
        check("t4_prog_mode", 32'(prog_mode), 0);
        check("t4_busy", 32'(busy), 0);
        check("t4_done", 32'(done), 0);
        check("t4_in_ready", 32'(in_ready), 0);
        check("t4_prog_addr", 32'(prog_addr), 0);
        mon_en = 1'b1;
        run_case(4'd5, 0, 1'b0, 1'b0, 4'd0, "t4_reload");

        // stray start while busy, then restart from DONE with error pending
        for (int i = 0; i < 16; i++) src[i] = 8'($urandom);
        corrupt_en[1]  = 1'b1;
        corrupt_val[1] = ~src[1];
        run_case(4'd3, 0, 1'b1, 1'b1, 4'd1, "t6_stray");
        check("t6_done_held", 32'(done), 1);
        check("t6_error_held", 32'(error), 1);
        corrupt_en[1] = 1'b0;
        run_case(4'd1, 2, 1'b0, 1'b0, 4'd0, "t6_restart");

        // no-verify instance: single byte at address 0
        nv_we_cycles = 0;
        nv_oe_cycles = 0;
        @(negedge clk);
        nv_start = 1'b1; nv_last = 4'd0;
        @(negedge clk);
        nv_start = 1'b0;
        check("nv_ready", 32'(nv_in_ready), 1);
        nv_in_valid = 1'b1;
        nv_in_data  = 8'hA5;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) nv_in_valid = 1'b0;
            check($sformatf("nv_done_k%0d", k), 32'(nv_done), (k == 5) ? 1 : 0);
        end
        check("nv_we_cycles", nv_we_cycles, 2);
        check("nv_we_addr", 32'(nv_we_addr), 0);
        check("nv_we_data", 32'(nv_we_data), 32'h A5);
        check("nv_oe_cycles", nv_oe_cycles, 0);
        check("nv_busy", 32'(nv_busy), 0);
        check("nv_error", 32'(nv_error), 0);

        // randomized loads against the reference model
        for (int r = 0; r < 8; r++) begin
            r_last = 4'($urandom_range(0, 15));
            r_gap  = $urandom_range(0, 2);
            for (int i = 0; i < 16; i++) begin
                src[i]         = 8'($urandom);
                corrupt_en[i]  = ($urandom_range(0, 5) == 0);
                corrupt_val[i] = ($urandom_range(0, 3) == 0) ? src[i] : 8'($urandom);
            end
            model_verify(r_last, m_err, m_ea);
            run_case(r_last, r_gap, 1'b0, m_err, m_ea, $sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
Automated programmer for the 16-byte SAP RAM's programming-mode interface. It replaces hand-set address/data switches and the write button. It accepts a byte stream over a valid/ready handshake, writes bytes to consecutive addresses from 0 with timed write strobes, then optionally reads every location back and compares it. It sits between a host/serial front end and the RAM; while it is busy the RAM is held in programming mode.

Parameters:
ADDR_WIDTH, 4, RAM address width (16 locations)
DATA_WIDTH, 8, RAM word width
SETUP_CYCLES, 1, address/data stable cycles before a write strobe or read compare (>=1)
PULSE_CYCLES, 2, width of the prog_we strobe (>=1)
HOLD_CYCLES, 1, address/data held after the strobe falls (>=1)
VERIFY, 1, 1 = read back and compare after the write pass; 0 = skip

Ports:
clk  in  1  system clock, rising edge
clear  in  1  synchronous active-high reset
start  in  1  begin a load; sampled only in IDLE or DONE
last_addr  in  ADDR_WIDTH  final address to write, inclusive; captured on accepted start
in_data  in  DATA_WIDTH  stream byte
in_valid  in  1  in_data valid
in_ready  out  1  loader will accept a byte this cycle
prog_mode  out  1  selects switch/programming path in RAM; high while busy
prog_addr  out  ADDR_WIDTH  address to RAM address register
prog_addr_load  out  1  one-cycle pulse to load prog_addr into the address register
prog_data  out  DATA_WIDTH  write data, true polarity (RAM handles internal inversion)
prog_we  out  1  active-high write strobe
ram_oe  out  1  RAM output enable during verify
ram_rdata  in  DATA_WIDTH  RAM read data
busy  out  1  not in IDLE/DONE
done  out  1  load (and verify) finished; held
error  out  1  sticky verify mismatch
err_addr  out  ADDR_WIDTH  first mismatching address

Behaviour:
- Reset (clear high at an edge): state=IDLE. All outputs 0: prog_addr, prog_data, err_addr=0; in_ready, prog_mode, prog_addr_load, prog_we, ram_oe, busy, done, error=0. Shadow buffer contents are don't-care.
- Clear mid-operation takes priority over everything. prog_we and ram_oe drop on that same edge. A partial write pass is abandoned and not resumed.
- States: IDLE, WAIT_BYTE, W_SETUP, W_PULSE, W_HOLD, V_SETUP, V_CHECK, DONE.
- IDLE/DONE with start=1: capture last_addr, set addr=0, clear done/error/err_addr, go to WAIT_BYTE. prog_mode=1 from the next cycle.
- WAIT_BYTE: in_ready=1. On in_valid&in_ready:
  - prog_data<=in_data
  - shadow[addr]<=in_data
  - go to W_SETUP.
  - A stalled stream waits indefinitely; there is no timeout.
- W_SETUP: SETUP_CYCLES cycles. prog_addr_load=1 in the first cycle only.
- W_PULSE: prog_we=1 for exactly PULSE_CYCLES cycles.
- W_HOLD: HOLD_CYCLES cycles, prog_we=0, addr/data unchanged. Then:
  - if addr==last_addr: go to V_SETUP with addr=0 when VERIFY=1, otherwise to DONE.
  - else: addr+1, go to WAIT_BYTE.
- Default cost per byte = 1 accept + 1 + 2 + 1 = 5 cycles.
- V_SETUP: prog_addr_load=1 in the first cycle, ram_oe=1 throughout, for SETUP_CYCLES cycles.
- V_CHECK: one cycle, ram_oe=1. Compare ram_rdata with shadow[addr].
  - On mismatch with error=0: set error=1, err_addr<=addr.
  - Later mismatches leave err_addr unchanged.
  - Then: if addr==last_addr go to DONE, else addr+1 and go to V_SETUP.
- DONE: done=1, prog_mode=0, busy=0, error/err_addr held until the next accepted start or clear.
- start while busy is ignored.
- Address counter never wraps: the pass always ends at last_addr. last_addr=0 writes exactly one byte; last_addr=15 writes all 16.
- prog_we and ram_oe are never high in the same cycle.
- in_ready=0 in every state except WAIT_BYTE.

Test Plan:
1. clear, start with last_addr=3, stream 0x11,0x22,0x33,0x44 with in_valid continuous and RAM model correct -> 4 prog_we pulses of 2 cycles each at addresses 0..3, done=1, error=0, busy low 1 cycle after the final V_CHECK.
2. last_addr=15, stream 0x00..0x0F with in_valid toggled every other cycle -> 16 writes in address order, no byte lost or duplicated, in_ready high only in WAIT_BYTE.
3. RAM model corrupts addr 5 (returns 0xFF) and addr 9 -> error=1, err_addr=5, all 16 locations still checked, done=1.
4. Assert clear during the W_PULSE of byte 2 -> prog_we=0 and prog_mode=0 on the next edge, state IDLE, done=0; then start and reload -> normal completion.
5. VERIFY=0, last_addr=0, one byte 0xA5 -> single write at addr 0, ram_oe never asserted, done after 5 cycles from byte accept.
6. start pulsed during WAIT_BYTE and again in DONE -> first ignored; second clears done/error and restarts at addr 0 with the new last_addr.
